// File: rtl/piso.sv
// Parallel-in, serial-out shift register with a valid/ready word interface.
// A word is loaded on the accept edge and shifted out one bit per clock; a new word can be
// accepted while the last bit of the current one is on the line, so words stream gap-free.
module piso #(
  parameter int unsigned BITS        = 8,
  parameter bit          SHIFT_RIGHT = 1'b1,
  parameter bit          IDLE_LEVEL  = 1'b0
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic [BITS-1:0] in_parallel,
  input  logic            in_valid,
  output logic            out_ready,
  output logic            out_serial,
  output logic            out_bit_valid,
  output logic            out_last,
  output logic            out_busy
);

  localparam int unsigned   CntW    = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BITS - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e            state_q;
  logic [BITS-1:0]   shiftreg_q;
  logic [CntW-1:0]   bitcnt_q;
  logic              serial_q;
  logic              bit_valid_q;
  logic              last_q;

  logic              on_last;
  logic              accept;
  logic              load_bit;
  logic              next_bit;
  logic [BITS-1:0]   shifted;

  // Ready while idle, or while the final bit of the current word is on the line.
  assign on_last   = (state_q == StShift) && (bitcnt_q == LastCnt);
  assign out_ready = (state_q == StIdle) || on_last;
  assign accept    = in_valid && out_ready;

  // Select the bit that leaves first on a load, and the bit that follows on a shift.
  always_comb begin
    load_bit = 1'b0;
    next_bit = 1'b0;
    shifted  = '0;
    if (SHIFT_RIGHT) begin
      load_bit = in_parallel[0];
      next_bit = shiftreg_q[1];
      shifted  = shiftreg_q >> 1;
    end else begin
      load_bit = in_parallel[BITS-1];
      next_bit = shiftreg_q[BITS-2];
      shifted  = shiftreg_q << 1;
    end
  end

  // Word FSM; all line outputs are registered here.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q     <= StIdle;
      shiftreg_q  <= '0;
      bitcnt_q    <= '0;
      serial_q    <= IDLE_LEVEL;
      bit_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else if (accept) begin
      state_q     <= StShift;
      shiftreg_q  <= in_parallel;
      bitcnt_q    <= '0;
      serial_q    <= load_bit;
      bit_valid_q <= 1'b1;
      last_q      <= 1'b0;
    end else if (state_q == StShift) begin
      if (!on_last) begin
        shiftreg_q  <= shifted;
        bitcnt_q    <= bitcnt_q + CntOne;
        serial_q    <= next_bit;
        bit_valid_q <= 1'b1;
        last_q      <= ((bitcnt_q + CntOne) == LastCnt);
      end else begin
        state_q     <= StIdle;
        serial_q    <= IDLE_LEVEL;
        bit_valid_q <= 1'b0;
        last_q      <= 1'b0;
      end
    end
  end

  assign out_serial    = serial_q;
  assign out_bit_valid = bit_valid_q;
  assign out_last      = last_q;
  assign out_busy      = (state_q == StShift);

endmodule
